instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the immediate-extend path: takes decoded fields plus a 64-bit signed immediate and packs them into a 32-bit RV64 instruction word.
- Immediate is placed in I/S/B/U/J layout.
- Used by the instruction-memory loader and self-test sequencer to build program images.
- Valid/ready input and output handshake, one registered output stage, immediate range checking, sticky error flag, word-address counter for each emitted instruction.

Parameters:
ADDR_W, 10, width of the emitted word-address counter (wraps modulo 2^ADDR_W)
NOP_WORD, 32'h00000013, word emitted for an illegal fmt code

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input fields valid
in_ready  out  1  encoder can accept this cycle
fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6..7 illegal
opcode  in  7  instr[6:0]
rd  in  5  destination register (R/I/U/J)
rs1  in  5  source 1 (R/I/S/B)
rs2  in  5  source 2 (R/S/B)
funct3  in  3  instr[14:12] (R/I/S/B)
funct7  in  7  instr[31:25] (R only)
imm  in  64  signed byte-offset/immediate (two's complement)
out_valid  out  1  instr/addr/err valid
out_ready  in  1  consumer accepts
instr  out  32  encoded instruction
addr  out  ADDR_W  word address of this instr (0,1,2,...)
err  out  1  range/format error on this instr
err_sticky  out  1  OR of all err since reset or clr
clr  in  1  synchronous; clears err_sticky and addr counter

Behaviour:
- Reset (rst_n=0, async): out_valid=0, instr=0, addr=0, err=0, err_sticky=0, internal address counter=0. Any held output is discarded.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- On accept, next cycle: out_valid=1, instr/err = encode(inputs), addr = counter. Latency 1 cycle. Full throughput with out_ready held high.
- Counter increments by 1 on each accept and wraps from 2^ADDR_W-1 to 0.
- No accept while out_valid && !out_ready: instr/addr/err held stable, in_ready=0.
- out_valid falls only on a handshake with no new accept in the same cycle.
- Encoding (unused fields ignored):
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Range check (err=1 when violated; instr still encoded from truncated bits):
  - I/S: imm must equal sign-extension of imm[11:0].
  - B: sign-extension of imm[12:0], and imm[0]=0.
  - J: sign-extension of imm[20:0], and imm[0]=0.
  - U: imm[11:0]=0, and imm equals sign-extension of imm[31:0].
  - R: imm ignored, never an error.
- fmt 6/7: instr=NOP_WORD, err=1.
- err_sticky sets on the cycle an err=1 word is loaded into the output register.
- clr:
  - Clears err_sticky and counter.
  - If clr and an erroring accept occur together, err_sticky=1 and the accepted word gets addr=0; counter becomes 1.
  - clr does not affect a held output.
- Reset mid-handshake drops the pending word; the bench must re-issue it.

Test Plan:
- Reset then I-type, opcode 0x13, rd=1, rs1=0, f3=0, imm=-1 -> next cycle out_valid=1, instr=0xFFF00093, addr=0, err=0.
- Back-to-back, out_ready=1:
  - S opcode 0x23, f3=3, rs1=3, rs2=2, imm=8 -> 0x0021B423, addr=0.
  - B opcode 0x63, rs1=rs2=0, imm=-4 -> 0xFE000EE3, addr=1.
  - J opcode 0x6F, rd=1, imm=0x800 -> 0x001000EF, addr=2.
  - U opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7, addr=3.
- Range errors:
  - I imm=2048 -> err=1, err_sticky=1.
  - B imm=6 then imm=5 -> first err=0, second err=1.
  - fmt=7 -> instr=0x00000013, err=1.
  - clr -> err_sticky=0, next addr=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, instr/addr stable; release -> one word per cycle, no loss or duplication.
- Wrap, ADDR_W=2: 5 accepts -> addr sequence 0,1,2,3,0.
- Async reset asserted mid-stall with out_valid=1 -> out_valid, err_sticky, addr drop to 0 immediately without a clock edge.

Source files
------------

// File: rtl/instr_encoder.sv
// Packs decoded RV64 fields and a signed 64-bit immediate into a 32-bit instruction word.
// Registered output with valid/ready handshake, immediate range checking and word-address tagging.
module instr_encoder #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [63:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] addr,
  output logic              err,
  output logic              err_sticky,
  input  logic              clr
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Returns {err, word}; the word is always built from the truncated immediate bits.
  function automatic logic [32:0] encode(
    input logic [2:0]  f,
    input logic [6:0]  op,
    input logic [4:0]  d,
    input logic [4:0]  s1,
    input logic [4:0]  s2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [63:0] im
  );
    logic [31:0] w;
    logic        e;
    w = 32'h0000_0000;
    e = 1'b0;
    case (f)
      FMT_R: begin
        w = {f7, s2, s1, f3, d, op};
        e = 1'b0;
      end
      FMT_I: begin
        w = {im[11:0], s1, f3, d, op};
        e = (im != {{52{im[11]}}, im[11:0]});
      end
      FMT_S: begin
        w = {im[11:5], s2, s1, f3, im[4:0], op};
        e = (im != {{52{im[11]}}, im[11:0]});
      end
      FMT_B: begin
        w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
        e = (im != {{51{im[12]}}, im[12:0]}) || im[0];
      end
      FMT_U: begin
        w = {im[31:12], d, op};
        e = (im[11:0] != 12'h000) || (im != {{32{im[31]}}, im[31:0]});
      end
      FMT_J: begin
        w = {im[20], im[10:1], im[11], im[19:12], d, op};
        e = (im != {{43{im[20]}}, im[20:0]}) || im[0];
      end
      default: begin
        w = NOP_WORD;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  logic              out_valid_q, out_valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              err_sticky_q, err_sticky_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              accept_s;
  logic [32:0]       enc_s;

  assign in_ready = !out_valid_q || out_ready;
  assign accept_s = in_valid && in_ready;
  assign enc_s    = encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);

  // Next-state for the output stage, address counter and sticky error.
  always_comb begin
    out_valid_d  = out_valid_q;
    instr_d      = instr_q;
    addr_d       = addr_q;
    err_d        = err_q;
    err_sticky_d = clr ? 1'b0 : err_sticky_q;
    cnt_d        = clr ? ADDR_ZERO : cnt_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      instr_d     = enc_s[31:0];
      err_d       = enc_s[32];
      // A clear coinciding with an accept tags this word as address 0.
      addr_d      = clr ? ADDR_ZERO : cnt_q;
      cnt_d       = clr ? ADDR_ONE : cnt_q + ADDR_ONE;
      if (enc_s[32]) begin
        err_sticky_d = 1'b1;
      end else begin
        err_sticky_d = clr ? 1'b0 : err_sticky_q;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      instr_q      <= 32'h0000_0000;
      addr_q       <= ADDR_ZERO;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      cnt_q        <= ADDR_ZERO;
    end else begin
      out_valid_q  <= out_valid_d;
      instr_q      <= instr_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign instr      = instr_q;
  assign addr       = addr_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed plan steps plus randomized fields
// checked against an arithmetic reference encoder and an address/sticky-error model.
module tb_instr_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    fmt = 3'd0;
  logic [6:0]    opcode = 7'd0;
  logic [4:0]    rd = 5'd0;
  logic [4:0]    rs1 = 5'd0;
  logic [4:0]    rs2 = 5'd0;
  logic [2:0]    funct3 = 3'd0;
  logic [6:0]    funct7 = 7'd0;
  logic [63:0]   imm = 64'd0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   instr;
  logic [AW-1:0] addr;
  logic          err;
  logic          err_sticky;
  logic          clr = 1'b0;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  int          model_cnt = 0;
  bit          model_sticky = 1'b0;
  logic [31:0] exp_instr;
  logic        exp_err;
  int          exp_addr;
  logic [63:0] bnd [0:12];

  instr_encoder #(.ADDR_W(AW), .NOP_WORD(32'h00000013)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .addr(addr),
    .err(err), .err_sticky(err_sticky), .clr(clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: field placement by shift/mask, ranges by signed comparison.
  task automatic ref_enc(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [63:0] u,
                         output logic [31:0] w, output logic e);
    longint      s;
    logic [63:0] r;
    s = signed'(u);
    r = (64'(s1) << 15) | (64'(f3) << 12) | 64'(op);
    case (f)
      3'd0: begin
        r = r | (64'(f7) << 25) | (64'(s2) << 20) | (64'(d) << 7);
        e = 1'b0;
      end
      3'd1: begin
        r = r | ((u & 64'hfff) << 20) | (64'(d) << 7);
        e = (s < -64'sd2048) || (s > 64'sd2047);
      end
      3'd2: begin
        r = r | (((u >> 5) & 64'h7f) << 25) | (64'(s2) << 20) | ((u & 64'h1f) << 7);
        e = (s < -64'sd2048) || (s > 64'sd2047);
      end
      3'd3: begin
        r = r | (((u >> 12) & 64'h1) << 31) | (((u >> 5) & 64'h3f) << 25) | (64'(s2) << 20)
              | (((u >> 1) & 64'hf) << 8) | (((u >> 11) & 64'h1) << 7);
        e = (s < -64'sd4096) || (s > 64'sd4095) || ((u & 64'h1) != 64'h0);
      end
      3'd4: begin
        r = (u & 64'hffff_f000) | (64'(d) << 7) | 64'(op);
        e = ((u & 64'hfff) != 64'h0) || (s < -64'sd2147483648) || (s > 64'sd2147483647);
      end
      3'd5: begin
        r = (((u >> 20) & 64'h1) << 31) | (((u >> 1) & 64'h3ff) << 21) | (((u >> 11) & 64'h1) << 20)
          | (((u >> 12) & 64'hff) << 12) | (64'(d) << 7) | 64'(op);
        e = (s < -64'sd1048576) || (s > 64'sd1048575) || ((u & 64'h1) != 64'h0);
      end
      default: begin
        r = 64'h13;
        e = 1'b1;
      end
    endcase
    w = r[31:0];
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [63:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    ref_enc(f, op, d, s1, s2, f3, f7, im, exp_instr, exp_err);
  endtask

  // Clocks in the driven word (in_ready must already be high) and checks the output stage.
  task automatic accept_check(input string tag);
    exp_addr     = clr ? 0 : model_cnt;
    model_cnt    = (exp_addr + 1) % DEPTH;
    model_sticky = (clr ? 1'b0 : model_sticky) | exp_err;
    @(posedge clk); #1;
    in_valid = 1'b0;
    clr = 1'b0;
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".instr"}, 64'(instr), 64'(exp_instr));
    chk({tag, ".addr"}, 64'(addr), 64'(exp_addr));
    chk({tag, ".err"}, 64'(err), 64'(exp_err));
    chk({tag, ".err_sticky"}, 64'(err_sticky), 64'(model_sticky));
  endtask

  task automatic issue(input string tag, input logic [2:0] f, input logic [6:0] op,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [63:0] im);
    drive(f, op, d, s1, s2, f3, f7, im);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    accept_check(tag);
  endtask

  task automatic idle(input string tag);
    @(posedge clk); #1;
    chk({tag, ".idle_valid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic do_clr(input string tag);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_cnt = 0;
    model_sticky = 1'b0;
    chk({tag, ".sticky_clr"}, 64'(err_sticky), 64'd0);
  endtask

  initial begin
    logic [31:0] held_instr;
    int          held_addr;
    int          wseq[5] = '{0, 1, 2, 3, 0};
    bnd[0] = 64'd2047;   bnd[1] = 64'd2048;   bnd[2] = -64'sd2048; bnd[3] = -64'sd2049;
    bnd[4] = 64'd4094;   bnd[5] = 64'd4095;   bnd[6] = -64'sd4096; bnd[7] = -64'sd4098;
    bnd[8] = 64'd1048574; bnd[9] = 64'd1048576; bnd[10] = -64'sd1048576;
    bnd[11] = 64'h7fff_f000; bnd[12] = 64'h8000_0000;

    // Reset state
    #12;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.instr", 64'(instr), 64'd0);
    chk("rst.addr", 64'(addr), 64'd0);
    chk("rst.err_sticky", 64'(err_sticky), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue("tp_i", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd1);
    chk("tp_i.const", 64'(instr), 64'hFFF00093);
    idle("tp_i");

    // Back-to-back with a fresh counter
    do_clr("b2b");
    issue("b2b_s", 3'd2, 7'h23, 5'd0, 5'd3, 5'd2, 3'd3, 7'd0, 64'd8);
    chk("b2b_s.const", 64'(instr), 64'h0021B423);
    issue("b2b_b", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd4);
    chk("b2b_b.const", 64'(instr), 64'hFE000EE3);
    issue("b2b_j", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'h800);
    chk("b2b_j.const", 64'(instr), 64'h001000EF);
    issue("b2b_u", 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h1234_5000);
    chk("b2b_u.const", 64'(instr), 64'h123452B7);
    chk("b2b_u.addr3", 64'(addr), 64'd3);

    // Range errors
    issue("err_i", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048);
    chk("err_i.err", 64'(err), 64'd1);
    chk("err_i.sticky", 64'(err_sticky), 64'd1);
    do_clr("err_clr0");
    issue("err_b6", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd6);
    chk("err_b6.err", 64'(err), 64'd0);
    issue("err_b5", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd5);
    chk("err_b5.err", 64'(err), 64'd1);
    issue("err_f7", 3'd7, 7'h33, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1, 64'd0);
    chk("err_f7.nop", 64'(instr), 64'h00000013);
    do_clr("err_clr");
    issue("clr_next", 3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 64'd0);
    chk("clr_next.addr0", 64'(addr), 64'd0);

    // clr together with an erroring accept
    clr = 1'b1;
    issue("clr_acc", 3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
    issue("clr_acc_next", 3'd1, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 64'd5);
    chk("clr_acc_next.addr1", 64'(addr), 64'd1);

    // Backpressure
    idle("bp_drain");
    out_ready = 1'b0;
    issue("bp_a", 3'd1, 7'h13, 5'd7, 5'd8, 5'd0, 3'd2, 7'd0, 64'd100);
    held_instr = exp_instr;
    held_addr  = exp_addr;
    drive(3'd2, 7'h23, 5'd0, 5'd9, 5'd10, 3'd2, 7'd0, -64'sd20);
    for (int i = 0; i < 3; i++) begin
      chk("bp.in_ready", 64'(in_ready), 64'd0);
      chk("bp.instr_held", 64'(instr), 64'(held_instr));
      chk("bp.addr_held", 64'(addr), 64'(held_addr));
      chk("bp.valid_held", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    accept_check("bp_b");
    issue("bp_c", 3'd4, 7'h17, 5'd11, 5'd0, 5'd0, 3'd0, 7'd0, 64'hffff_ffff_fff0_0000);
    idle("bp_end");

    // Counter wrap
    do_clr("wrap");
    for (int i = 0; i < 5; i++) begin
      issue("wrap", 3'd0, 7'h33, 5'(i), 5'd1, 5'd2, 3'd0, 7'd0, 64'd0);
      chk("wrap.seq", 64'(addr), 64'(wseq[i]));
    end

    // Randomized words with occasional gaps
    for (int n = 0; n < 150; n++) begin
      logic [63:0] im;
      logic [31:0] r;
      if ($urandom_range(0, 3) == 0) idle("rnd_gap");
      r = $urandom;
      case ($urandom_range(0, 4))
        0: im = 64'(longint'($urandom_range(0, 8191)) - 64'sd4096);
        1: im = {$urandom, $urandom};
        2: im = {{32{r[31]}}, r & 32'hffff_f000};
        3: im = bnd[$urandom_range(0, 12)];
        default: im = 64'(longint'($urandom_range(0, 2097151)) - 64'sd1048576);
      endcase
      if ($urandom_range(0, 15) == 0) clr = 1'b1;
      issue("rnd", 3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom), 3'($urandom), 7'($urandom), im);
    end

    // Async reset while stalled
    idle("rst_drain");
    out_ready = 1'b0;
    issue("rst_a", 3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 64'(out_valid), 64'd0);
    chk("arst.err_sticky", 64'(err_sticky), 64'd0);
    chk("arst.addr", 64'(addr), 64'd0);
    chk("arst.instr", 64'(instr), 64'd0);
    #2 rst_n = 1'b1;
    model_cnt = 0;
    model_sticky = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue("rst_reissue", 3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
    chk("rst_reissue.addr0", 64'(addr), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
